// File: rtl/fpu_pkg.sv
// fpu_pkg: shared types, flag indices and helpers for the FPU conversion blocks.
package fpu_pkg;
  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_ALIGN, S_ROUND, S_OUT} fpu_f2i_state_e;
  typedef enum logic [2:0] {RNE, RTZ, RDN, RUP, RMM} fpu_rm_e;
  localparam int FLAG_NV = 4;
  localparam int FLAG_NX = 0;
  function automatic int f2i_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction
endpackage

// File: rtl/fpu_round_inc.sv
// fpu_round_inc: round-increment decision from sign, lsb, guard and sticky; rm 5..7 never increments.
module fpu_round_inc
  import fpu_pkg::*;
(
  input  logic [2:0] rm,
  input  logic       sign,
  input  logic       lsb,
  input  logic       guard,
  input  logic       sticky,
  output logic       inc
);
  always_comb
    inc = rm == RNE ? guard & (sticky | lsb) :
          rm == RDN ? sign & (guard | sticky) :
          rm == RUP ? ~sign & (guard | sticky) :
          rm == RMM ? guard : 1'b0;
endmodule

// File: rtl/fpu_f2i_gen.sv
// fpu_f2i_gen: parametrised IEEE-754 float to signed/unsigned integer converter with NV/NX flags.
// FPU_F2I_ROUND_EN adds rm support and a ROUND stage; without it RTZ is used and latency drops to 3.
module fpu_f2i_gen
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int INT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [EXP_W+MAN_W:0] din,
  input  logic                 dval,
  input  logic                 is_unsigned,
  input  logic [2:0]           rm,
  output logic                 din_rdy,
  output logic [INT_W-1:0]     result,
  output logic [4:0]           fflags,
  output logic                 rdy
);
  localparam int X = INT_W + MAN_W + 1;
  localparam logic [INT_W-1:0] MAX_POS = {1'b0, {INT_W-1{1'b1}}};
  localparam logic [INT_W:0] MIN_NEG_MAG = {2'b01, {INT_W-1{1'b0}}};
  fpu_f2i_state_e r_state, w_next;
  logic r_sign, r_uns;
  logic [2:0] r_rm, w_rm;
  logic [EXP_W-1:0] r_exp;
  logic [MAN_W-1:0] r_man;
  logic signed [EXP_W:0] r_e;
  logic [MAN_W:0] r_mant;
  logic r_zero, r_sub, r_nan, r_inf;
  logic [INT_W-1:0] r_mag, w_mag, w_res;
  logic r_g, r_s, r_ovf, w_g, w_s, w_ovf, w_small, w_inc, w_nv, w_nx;
  logic [X-1:0] w_ext;
  logic [INT_W:0] w_rnd, w_rmag;
`ifdef FPU_F2I_ROUND_EN
  localparam fpu_f2i_state_e AFTER_ALIGN = S_ROUND;
  logic [INT_W:0] r_rmag;
  assign w_rm = r_rm;
  assign w_rmag = r_rmag;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_rmag <= '0;
    else if (r_state == S_ROUND) r_rmag <= w_rnd;
`else
  localparam fpu_f2i_state_e AFTER_ALIGN = S_OUT;
  logic w_unused_rm;
  assign w_unused_rm = ^r_rm;
  assign w_rm = RTZ;
  assign w_rmag = w_rnd;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    din_rdy = 1'b0;
    case (r_state)
      S_IDLE: begin
        din_rdy = 1'b1;
        w_next = dval ? S_UNPACK : S_IDLE;
      end
      S_UNPACK: w_next = S_ALIGN;
      S_ALIGN: w_next = AFTER_ALIGN;
      S_ROUND: w_next = S_OUT;
      default: w_next = S_IDLE;
    endcase
  end
  // Fixed point with MAN_W+1 fraction bits: integer part on top, guard just below the point.
  always_comb begin
    w_small = r_sub | r_e[EXP_W];
    w_ext = {{INT_W-1{1'b0}}, r_mant, 1'b0} << r_e;
    w_ovf = r_nan | r_inf | (int'(r_e) >= INT_W);
    w_mag = (w_small | w_ovf) ? '0 : w_ext[X-1 -: INT_W];
    w_g = w_small ? &r_e : w_ext[MAN_W];
    w_s = w_small ? (&r_e ? |r_mant[MAN_W-1:0] : |r_mant) : |w_ext[MAN_W-1:0];
  end
  fpu_round_inc u_round (
    .rm(w_rm), .sign(r_sign), .lsb(r_mag[0]), .guard(r_g), .sticky(r_s), .inc(w_inc)
  );
  assign w_rnd = {1'b0, r_mag} + (INT_W+1)'(w_inc);
  always_comb begin
    w_nv = 1'b0;
    w_res = '0;
    if (r_nan) begin
      w_nv = 1'b1;
      w_res = r_uns ? '1 : MAX_POS;
    end else if (r_uns && r_sign) w_nv = r_ovf | (|w_rmag);
    else if (r_uns) begin
      w_nv = r_ovf | w_rmag[INT_W];
      w_res = w_nv ? '1 : w_rmag[INT_W-1:0];
    end else if (r_sign) begin
      w_nv = r_ovf | (w_rmag > MIN_NEG_MAG);
      w_res = w_nv ? ~MAX_POS : -w_rmag[INT_W-1:0];
    end else begin
      w_nv = r_ovf | (w_rmag > {1'b0, MAX_POS});
      w_res = w_nv ? MAX_POS : w_rmag[INT_W-1:0];
    end
    w_nx = (r_g | r_s) & ~w_nv & ~r_zero;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r_sign, r_exp, r_man, r_uns, r_rm} <= '0;
      {r_e, r_mant, r_zero, r_sub, r_nan, r_inf} <= '0;
      {r_mag, r_g, r_s, r_ovf} <= '0;
      result <= '0;
      fflags <= '0;
      rdy <= 1'b0;
    end else begin
      rdy <= r_state == S_OUT;
      if (r_state == S_IDLE && dval) {r_sign, r_exp, r_man, r_uns, r_rm} <= {din, is_unsigned, rm};
      if (r_state == S_UNPACK) begin
        r_e <= $signed({1'b0, r_exp} - (EXP_W+1)'(f2i_bias(EXP_W)));
        r_mant <= {|r_exp, r_man};
        r_zero <= ~|r_exp & ~|r_man;
        r_sub <= ~|r_exp & |r_man;
        r_nan <= &r_exp & |r_man;
        r_inf <= &r_exp & ~|r_man;
      end
      if (r_state == S_ALIGN) {r_mag, r_g, r_s, r_ovf} <= {w_mag, w_g, w_s, w_ovf};
      if (r_state == S_OUT) begin
        result <= w_res;
        fflags <= (5'(w_nv) << FLAG_NV) | (5'(w_nx) << FLAG_NX);
      end
    end
  end
endmodule

// File: tb/tb_fpu_f2i_gen.sv
// tb_fpu_f2i_gen: directed vectors for the float-to-int converter (single precision and half/16-bit instance).
module tb_fpu_f2i_gen;
`ifdef FPU_F2I_ROUND_EN
  localparam int LAT = 4;
  localparam logic [31:0] M25 [5] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'hFFFFFFFD};
  localparam logic [31:0] HALF_RUP = 32'd1;
`else
  localparam int LAT = 3;
  localparam logic [31:0] M25 [5] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE};
  localparam logic [31:0] HALF_RUP = 32'd0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] din = '0;
  logic dval = 1'b0, is_unsigned = 1'b0;
  logic [2:0] rm = '0;
  logic din_rdy, rdy;
  logic [31:0] result;
  logic [4:0] fflags;
  logic [15:0] h_din = '0;
  logic h_dval = 1'b0, h_uns = 1'b0;
  logic h_din_rdy, h_rdy;
  logic [15:0] h_result;
  logic [4:0] h_fflags;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  fpu_f2i_gen dut (
    .clk(clk), .rst_n(rst_n), .din(din), .dval(dval), .is_unsigned(is_unsigned), .rm(rm),
    .din_rdy(din_rdy), .result(result), .fflags(fflags), .rdy(rdy)
  );
  fpu_f2i_gen #(.EXP_W(5), .MAN_W(10), .INT_W(16)) dut_h (
    .clk(clk), .rst_n(rst_n), .din(h_din), .dval(h_dval), .is_unsigned(h_uns), .rm(3'd1),
    .din_rdy(h_din_rdy), .result(h_result), .fflags(h_fflags), .rdy(h_rdy)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic conv(input string tag, input logic [31:0] f, input logic uns, input logic [2:0] m,
                      input logic [31:0] er, input logic [4:0] ef, input logic poke);
    int lat = 0;
    int extra = 0;
    @(negedge clk);
    check({tag, "_din_rdy"}, din_rdy, 1);
    din = f; is_unsigned = uns; rm = m; dval = 1'b1;
    @(posedge clk); #1;
    dval = 1'b0;
    din = poke ? 32'h3F800000 : 32'h0;
    while (!rdy && lat < 10) begin
      if (lat == 1) check({tag, "_busy"}, din_rdy, 0);
      if (poke) dval = lat < 2;
      @(posedge clk); #1;
      lat++;
    end
    dval = 1'b0;
    check({tag, "_lat"}, lat, LAT);
    check({tag, "_res"}, result, er);
    check({tag, "_flg"}, fflags, ef);
    @(posedge clk); #1;
    check({tag, "_pulse"}, rdy, 0);
    if (poke) begin
      repeat (LAT + 1) begin
        @(posedge clk); #1;
        if (rdy) extra++;
      end
      check({tag, "_ignored"}, extra, 0);
      check({tag, "_hold"}, result, er);
    end
  endtask
  task automatic conv_h(input string tag, input logic [15:0] f, input logic [15:0] er, input logic [4:0] ef);
    int lat = 0;
    @(negedge clk);
    h_din = f; h_uns = 1'b0; h_dval = 1'b1;
    @(posedge clk); #1;
    h_dval = 1'b0;
    while (!h_rdy && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, LAT);
    check({tag, "_res"}, h_result, er);
    check({tag, "_flg"}, h_fflags, ef);
  endtask
  initial begin
    int extra = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_result", result, 0);
    check("rst_fflags", fflags, 0);
    check("rst_rdy", rdy, 0);
    check("rst_din_rdy", din_rdy, 1);
    @(negedge clk); rst_n = 1'b1;
    conv("pi", 32'h40490FDB, 1'b0, 3'd0, 32'd3, 5'h01, 1'b0);
    for (int i = 0; i < 5; i++) conv("m2p5", 32'hC0200000, 1'b0, 3'(i), M25[i], 5'h01, 1'b0);
    conv("p2_31", 32'h4F000000, 1'b0, 3'd0, 32'h7FFFFFFF, 5'h10, 1'b0);
    conv("n2_31", 32'hCF000000, 1'b0, 3'd0, 32'h80000000, 5'h00, 1'b1);
    @(negedge clk);
    din = 32'h40490FDB; rm = 3'd0; is_unsigned = 1'b0; dval = 1'b1;
    @(posedge clk); #1;
    dval = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_res", result, 0);
    check("abort_rdy", rdy, 0);
    check("abort_din_rdy", din_rdy, 1);
    @(negedge clk); rst_n = 1'b1;
    repeat (LAT + 2) begin
      @(posedge clk); #1;
      if (rdy) extra++;
    end
    check("abort_no_rdy", extra, 0);
    conv("nan_s", 32'h7FC00000, 1'b0, 3'd0, 32'h7FFFFFFF, 5'h10, 1'b0);
    conv("nan_u", 32'h7FC00000, 1'b1, 3'd0, 32'hFFFFFFFF, 5'h10, 1'b0);
    conv("m1_u", 32'hBF800000, 1'b1, 3'd0, 32'h0, 5'h10, 1'b0);
    conv("mq_u", 32'hBE800000, 1'b1, 3'd1, 32'h0, 5'h01, 1'b0);
    conv("p2_32_u", 32'h4F800000, 1'b1, 3'd0, 32'hFFFFFFFF, 5'h10, 1'b0);
    conv("big_u", 32'h4F7FFFFF, 1'b1, 3'd0, 32'hFFFFFF00, 5'h00, 1'b0);
    conv("half_rup", 32'h3F000000, 1'b0, 3'd3, HALF_RUP, 5'h01, 1'b0);
    conv("neg0", 32'h80000000, 1'b0, 3'd0, 32'h0, 5'h00, 1'b0);
    conv_h("h100", 16'h5640, 16'h0064, 5'h00);
    conv_h("hinf", 16'h7C00, 16'h7FFF, 5'h10);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end
endmodule
